// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// Holds the FSM state encoding and the last-served marker used for tie breaks.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    SERVED_I = 1'b0,
    SERVED_D = 1'b1
  } served_t;

  function automatic logic is_busy(arb_state_t s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the two cache pmem ports and the memory-side port.
// Handshake: a cache holds read/write until its resp pulses, then drops it; memory pulses mem_resp once per op.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter side.
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Caches plus memory model side.
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares the single memory port between I-cache and D-cache, one line op at a time.
// Requests are only arbitrated in ARB_IDLE; ties go to whichever cache was not served last.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus,
  output arb_state_t     arb_state
);

  arb_state_t        state_q, state_d;
  served_t           last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              i_req, d_req, grant_i, grant_d;

  always_comb begin
    i_req    = bus.i_read;
    d_req    = bus.d_read | bus.d_write;
    grant_d  = d_req & (~i_req | (last_q == SERVED_I));
    grant_i  = i_req & ~grant_d;
    state_d  = state_q;
    last_d   = last_q;
    bus.i_resp = 1'b0;
    bus.d_resp = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_d)      state_d = ARB_DCACHE;
        else if (grant_i) state_d = ARB_ICACHE;
      end
      ARB_ICACHE: begin
        if (bus.mem_resp) begin
          bus.i_resp = 1'b1;
          last_d     = SERVED_I;
          state_d    = ARB_IDLE;
        end
      end
      ARB_DCACHE: begin
        if (bus.mem_resp) begin
          bus.d_resp = 1'b1;
          last_d     = SERVED_D;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= SERVED_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Request capture: memory-side outputs come only from these, so a cache
  // changing its inputs mid-op cannot disturb the transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (state_q == ARB_IDLE && (grant_d || grant_i)) begin
      addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
      write_q <= grant_d & bus.d_write;
      if (grant_d) wdata_q <= bus.d_wdata;
    end
  end

  assign bus.mem_read  = is_busy(state_q) & ~write_q;
  assign bus.mem_write = is_busy(state_q) &  write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign arb_state     = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: requester/memory drivers feed the DUT,
// monitors pop expected memory ops and responses from queues and compare.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int CW = 1 + AW + LW;

  logic       clk;
  logic       rst;
  arb_state_t arb_state;

  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .arb_state (arb_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] mem_exp_q[$];
  logic [LW:0]   resp_exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_resp_cyc = 0;

  logic [LW-1:0] init_data = {8{32'h0BAD_F00D}};
  logic [LW-1:0] rd_val;
  int            mem_lat = 2;
  int            stray_req = 0;
  int            i_total = 0, i_served = 0;
  int            d_total = 0, d_served = 0;
  logic          d_wr = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata, input logic has_resp,
                            input logic [LW-1:0] rdata);
    mem_exp_q.push_back({wr, addr, wdata});
    if (has_resp) resp_exp_q.push_back({is_d, rdata});
  endtask

  // ---------------- requester driver (caches) ----------------
  initial begin
    logic i_seen, d_seen;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    forever begin
      @(negedge clk);
      i_seen = bus.i_resp;
      d_seen = bus.d_resp;
      @(posedge clk); #2;
      if (i_seen) i_served++;
      if (d_seen) d_served++;
      bus.i_read  = !i_seen && (i_served < i_total);
      bus.d_read  = !d_seen && (d_served < d_total) && !d_wr;
      bus.d_write = !d_seen && (d_served < d_total) &&  d_wr;
    end
  end

  // ---------------- memory model driver ----------------
  initial begin
    int cnt = 0;
    int stray_done = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = init_data;
    forever begin
      @(posedge clk); #3;
      if (!rst) begin
        bus.mem_resp = 1'b0;
        cnt = 0;
      end else if (bus.mem_resp) begin
        bus.mem_resp = 1'b0;
        cnt = 0;
      end else if (stray_req != stray_done) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd_val;
        stray_done    = stray_req;
      end else if (bus.mem_read || bus.mem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = rd_val;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    arb_state_t    prev = ARB_IDLE;
    logic [CW-1:0] e;
    logic [LW:0]   r;
    logic [1+AW+LW:0] snap, now;
    snap = '0;
    forever begin
      @(negedge clk);
      now = {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata};
      if (rst && arb_state != ARB_IDLE && prev == ARB_IDLE) begin
        if (mem_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected: got addr %h expected no op", bus.mem_addr);
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_op", CW'({bus.mem_write, bus.mem_read}), CW'({e[CW-1], ~e[CW-1]}));
          check("mem_addr", CW'(bus.mem_addr), CW'(e[LW +: AW]));
          if (e[CW-1]) check("mem_wdata", CW'(bus.mem_wdata), CW'(e[LW-1:0]));
          snap = now;
        end
      end
      if (rst && arb_state != ARB_IDLE && bus.mem_resp)
        check("mem_hold", CW'(now[1+AW+LW:LW]), CW'(snap[1+AW+LW:LW]));
      if (bus.i_resp || bus.d_resp) begin
        last_resp_cyc = cyc;
        if (bus.i_resp && bus.d_resp) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_both: got i_resp=1 d_resp=1 expected one");
        end else if (resp_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", bus.i_resp, bus.d_resp);
        end else begin
          r = resp_exp_q.pop_front();
          check("resp_id", CW'(bus.d_resp), CW'(r[LW]));
          check("resp_data", CW'(bus.d_resp ? bus.d_rdata : bus.i_rdata), CW'(r[LW-1:0]));
          check("resp_with_mem", CW'(bus.mem_resp), CW'(1'b1));
        end
      end
      prev = rst ? arb_state : ARB_IDLE;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input string name);
    int n = 0;
    while ((i_served < i_total || d_served < d_total ||
            mem_exp_q.size() != 0 || resp_exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 300) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d ops/%0d resps pending expected 0", name,
               mem_exp_q.size(), resp_exp_q.size());
      mem_exp_q.delete();
      resp_exp_q.delete();
      i_total = i_served;
      d_total = d_served;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_state(input arb_state_t s, input string name);
    int n = 0;
    @(negedge clk);
    while (arb_state != s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, CW'(arb_state), CW'(s));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t0;
    rst = 1'b0;
    rd_val = init_data;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", CW'(arb_state), CW'(ARB_IDLE));
    check("rst_mem_read", CW'(bus.mem_read), '0);
    check("rst_mem_write", CW'(bus.mem_write), '0);
    check("rst_mem_addr", CW'(bus.mem_addr), '0);
    check("rst_mem_wdata", CW'(bus.mem_wdata), '0);
    check("rst_resp", CW'({bus.i_resp, bus.d_resp}), '0);
    check("rst_i_rdata", CW'(bus.i_rdata), CW'(init_data));
    check("rst_d_rdata", CW'(bus.d_rdata), CW'(init_data));
    @(posedge clk); #1 rst = 1'b1;

    // Tie straight after reset: D, I, D, I.
    @(posedge clk); #1;
    bus.i_addr = 32'h40; bus.d_addr = 32'h200; d_wr = 1'b0;
    mem_lat = 2; rd_val = {8{32'h1111_2222}};
    expect_txn(1, 0, 32'h200, '0, 1, rd_val);
    expect_txn(0, 0, 32'h40,  '0, 1, rd_val);
    expect_txn(1, 0, 32'h200, '0, 1, rd_val);
    expect_txn(0, 0, 32'h40,  '0, 1, rd_val);
    i_total += 2; d_total += 2;
    wait_drain("tie_reset");

    // I only, response after 4 memory cycles.
    @(posedge clk); #1;
    bus.i_addr = 32'h60; mem_lat = 4; rd_val = {8{32'hAAAA_AAAA}};
    expect_txn(0, 0, 32'h60, '0, 1, rd_val);
    i_total++;
    @(negedge clk);
    t0 = cyc;
    check("i_cycle0_state", CW'(arb_state), CW'(ARB_IDLE));
    @(negedge clk);
    check("i_cycle1_read", CW'({bus.mem_read, bus.mem_write}), CW'(2'b10));
    check("i_cycle1_addr", CW'(bus.mem_addr), CW'(32'h60));
    wait_drain("i_only");
    check("i_resp_cycle", CW'(last_resp_cyc - t0), CW'(4));

    // D writeback.
    @(posedge clk); #1;
    bus.d_addr = 32'h100; bus.d_wdata = {8{32'h5555_5555}}; d_wr = 1'b1;
    mem_lat = 3; rd_val = {8{32'h0F0F_0F0F}};
    expect_txn(1, 1, 32'h100, {8{32'h5555_5555}}, 1, rd_val);
    d_total++;
    wait_drain("d_write");

    // Tie after D was served last: I wins.
    @(posedge clk); #1;
    bus.i_addr = 32'h500; bus.d_addr = 32'h600; bus.d_wdata = {8{32'h3333_3333}}; d_wr = 1'b1;
    mem_lat = 2; rd_val = {8{32'hDEAD_BEEF}};
    expect_txn(0, 0, 32'h500, '0, 1, rd_val);
    expect_txn(1, 1, 32'h600, {8{32'h3333_3333}}, 1, rd_val);
    i_total++; d_total++;
    wait_drain("tie_last_d");

    // Late D arrival while I is in flight.
    @(posedge clk); #1;
    bus.i_addr = 32'h300; d_wr = 1'b0; mem_lat = 5; rd_val = {8{32'h1234_5678}};
    expect_txn(0, 0, 32'h300, '0, 1, rd_val);
    expect_txn(1, 0, 32'h400, '0, 1, rd_val);
    i_total++;
    wait_state(ARB_ICACHE, "late_i_busy");
    @(posedge clk); #1;
    bus.d_addr = 32'h400; d_total++;
    wait_drain("late_arrival");

    // Reset two cycles into a D read.
    @(posedge clk); #1;
    bus.d_addr = 32'h700; d_wr = 1'b0; mem_lat = 20;
    expect_txn(1, 0, 32'h700, '0, 0, rd_val);
    d_total++;
    wait_state(ARB_DCACHE, "rst_d_busy");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; d_total = d_served;
    #1;
    check("midrst_mem_read", CW'(bus.mem_read), '0);
    check("midrst_d_resp", CW'(bus.d_resp), '0);
    check("midrst_state", CW'(arb_state), CW'(ARB_IDLE));
    check("midrst_mem_addr", CW'(bus.mem_addr), '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    bus.i_addr = 32'h80; mem_lat = 2; rd_val = {8{32'hCAFE_0001}};
    expect_txn(0, 0, 32'h80, '0, 1, rd_val);
    i_total++;
    wait_drain("post_rst_i");

    // Stray mem_resp in idle.
    @(posedge clk); #1;
    rd_val = {8{32'hFFFF_0000}};
    stray_req++;
    @(negedge clk);
    check("stray_resp", CW'({bus.i_resp, bus.d_resp}), '0);
    check("stray_state", CW'(arb_state), CW'(ARB_IDLE));
    @(negedge clk);
    check("stray_state_after", CW'(arb_state), CW'(ARB_IDLE));
    @(posedge clk); #1;
    bus.i_addr = 32'h90; mem_lat = 1; rd_val = {8{32'h7777_8888}};
    expect_txn(0, 0, 32'h90, '0, 1, rd_val);
    i_total++;
    wait_drain("post_stray_i");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
